roulette_brake: RTL and testbench
=================================

Name: roulette_brake

Overview:
- Step-strobe generator that sits directly upstream of the roulette display stage and replaces the raw counter-bit tap as its advance source.
- A debounced pushbutton starts the wheel spinning at a fixed fast rate.
- A second press starts braking: the interval between steps grows linearly until the wheel halts on its last position.
- Outputs a one-cycle step pulse per wheel advance plus status for LEDs.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on key_n (must be ≥2).
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles needed to accept a key level change (20 ms at 50 MHz).
- FAST_PERIOD, 2500000: cycles between steps in SPIN (must be ≥2).
- PERIOD_INC, 1250000: amount added to the period after each step in BRAKE (must be ≥1).
- SLOW_PERIOD, 25000000: maximum period; braking ends when the next period would exceed it (must be ≥ FAST_PERIOD).
- CW, 32: width of the period and tick counters (must hold SLOW_PERIOD+PERIOD_INC).

Ports:
- clk  in  1  system clock (CLOCK_50 at top level).
- nrst  in  1  reset, asynchronous, active-low.
- key_n  in  1  pushbutton, active-low, asynchronous to clk, bouncy.
- step  out  1  one-cycle advance strobe to the roulette stage.
- spinning  out  1  high in SPIN or BRAKE.
- braking  out  1  high in BRAKE.
- period  out  CW  current step period in cycles.

Behaviour:
- Reset (async, nrst low): all outputs and state update immediately, without waiting for clk.
  - Synchronizer flops = 1; debounced level db = 1; debounce counter = 0; press event = 0.
  - State = HALT; tick = 0; period = FAST_PERIOD; step = 0; spinning = 0; braking = 0.
  - Reset mid-spin or mid-brake: same immediate values; no further step is emitted.
- Input conditioning:
  - key_n passes through SYNC_STAGES flops to give ks.
  - When ks != db, the debounce counter increments; when ks == db, it clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 with ks != db still true, db <= ks and the counter clears.
  - press is a registered one-cycle pulse, high in the cycle after db goes 1->0.
  - A release (db 0->1) generates no event. Bounces shorter than DEBOUNCE_CYCLES produce no event.
- Tick counter (SPIN and BRAKE only):
  - tick increments each cycle.
  - When tick == period-1: step = 1 for that cycle and tick <= 0.
  - step is combinational from tick == period-1 while state != HALT; it is never high in HALT.
- HALT:
  - tick held at 0.
  - On press: state <= SPIN, period <= FAST_PERIOD, tick <= 0.
  - The first step follows FAST_PERIOD cycles after the transition edge.
- SPIN:
  - Period is fixed at FAST_PERIOD.
  - On press: state <= BRAKE. tick is NOT reset, so the braking phase keeps the current phase.
  - If press and step coincide: the step is emitted, state goes to BRAKE, and period is not incremented on that step.
- BRAKE:
  - press is ignored.
  - On each step, compute nxt = period + PERIOD_INC in CW bits.
  - If nxt <= SLOW_PERIOD: period <= nxt.
  - Otherwise this is the final step: it is still emitted, state <= HALT, period holds its value, tick <= 0.
- Status outputs are registered from state: spinning = (state != HALT), braking = (state == BRAKE).
- Other rules:
  - State encoding is free. An unreachable state returns to HALT.
  - No overflow handling is required given the CW constraint.

Test Plan:
- Bench parameters for all cases: DEBOUNCE_CYCLES=4, FAST_PERIOD=4, PERIOD_INC=2, SLOW_PERIOD=12, SYNC_STAGES=2.
- Reset then idle, key_n=1 for 50 cycles -> step never high; spinning=0; period=4.
- key_n glitches low for 2 cycles, three times with 2-cycle gaps -> no press; state stays HALT; step=0.
- key_n held low 10 cycles -> exactly one press; spinning=1 one cycle later; steps then every 4 cycles; release produces no change.
- During SPIN, a second clean press -> braking=1. Subsequent step gaps are 4 (remaining phase), 6, 8, 10, 12, giving exactly 5 steps in BRAKE. After the last one, spinning=0, braking=0, period=12, and no more steps.
- Press timed so press and step coincide in SPIN -> that step is seen, braking=1, period stays 4 until the next step, then becomes 6.
- Assert nrst low mid-BRAKE (asynchronously, between clk edges) -> step, spinning, braking go 0 and period=4 immediately. After nrst release, a new press restarts at a 4-cycle interval.

Source files
------------

// File: rtl/roulette_brake.sv
// roulette_brake: debounced key starts a fixed-rate step strobe; a second press
// brakes it, growing the step period linearly until the wheel halts.
module roulette_brake #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int FAST_PERIOD     = 2500000,
   parameter int PERIOD_INC      = 1250000,
   parameter int SLOW_PERIOD     = 25000000,
   parameter int CW              = 32
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          key_n,
   output logic          step,
   output logic          spinning,
   output logic          braking,
   output logic [CW-1:0] period
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   typedef enum logic [1:0] {HALT, SPIN, BRAKE} state_t;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_db;
   logic                   r_press;
   logic [DW-1:0]          r_dbcnt;
   state_t                 r_state;
   logic [CW-1:0]          r_tick;
   logic [CW-1:0]          r_period;
   logic                   r_spinning;
   logic                   r_braking;
   logic                   w_ks;
   logic                   w_db_done;
   logic                   w_step;
   logic [CW-1:0]          w_nxt;
   assign w_ks      = r_sync[SYNC_STAGES-1];
   assign w_db_done = (w_ks != r_db) && (r_dbcnt == DW'(DEBOUNCE_CYCLES - 1));
   assign w_step    = (r_state != HALT) && (r_tick == r_period - CW'(1));
   assign w_nxt     = r_period + CW'(PERIOD_INC);
   assign step      = w_step;
   assign spinning  = r_spinning;
   assign braking   = r_braking;
   assign period    = r_period;
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_sync  <= '1;
         r_db    <= 1'b1;
         r_dbcnt <= '0;
         r_press <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], key_n};
         r_dbcnt <= (w_ks == r_db || w_db_done) ? '0 : r_dbcnt + 1'b1;
         r_db    <= w_db_done ? w_ks : r_db;
         r_press <= w_db_done && !w_ks;
      end
   end
   // tick is left running on the SPIN->BRAKE transition so braking keeps the phase
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state    <= HALT;
         r_tick     <= '0;
         r_period   <= CW'(FAST_PERIOD);
         r_spinning <= 1'b0;
         r_braking  <= 1'b0;
      end else begin
         case (r_state)
            HALT: begin
               r_tick <= '0;
               if (r_press) begin
                  r_state    <= SPIN;
                  r_period   <= CW'(FAST_PERIOD);
                  r_spinning <= 1'b1;
               end
            end
            SPIN: begin
               r_tick <= w_step ? '0 : r_tick + 1'b1;
               if (r_press) begin
                  r_state   <= BRAKE;
                  r_braking <= 1'b1;
               end
            end
            BRAKE: begin
               r_tick <= w_step ? '0 : r_tick + 1'b1;
               if (w_step && w_nxt <= CW'(SLOW_PERIOD))
                  r_period <= w_nxt;
               else if (w_step) begin
                  r_state    <= HALT;
                  r_spinning <= 1'b0;
                  r_braking  <= 1'b0;
               end
            end
            default: begin
               r_state    <= HALT;
               r_tick     <= '0;
               r_spinning <= 1'b0;
               r_braking  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_roulette_brake.sv
// tb_roulette_brake: event-level wheel model compared every cycle, plus directed
// literal checks on press latency, brake gaps and asynchronous reset.
module tb_roulette_brake;
   localparam int SYNC = 2, DEB = 4, FAST = 4, INC = 2, SLOW = 12, CW = 32;
   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic          key_n = 1'b1;
   logic          step, spinning, braking;
   logic [CW-1:0] period;
   int            errs = 0, checks = 0, ncyc = 0;
   int            stimes[$];

   roulette_brake #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .FAST_PERIOD(FAST),
      .PERIOD_INC(INC), .SLOW_PERIOD(SLOW), .CW(CW)) dut (
      .clk(clk), .nrst(nrst), .key_n(key_n), .step(step),
      .spinning(spinning), .braking(braking), .period(period));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, ncyc);
      end
   endtask

   // Model: wheel tracked as absolute cycle numbers of the next due step.
   bit m_hist[$];
   bit m_db, m_press, m_spin, m_brake, m_ks, m_hit, m_fire, m_was_spin, m_was_brake;
   int m_run, m_period, cyc = 0, due = 0;

   function automatic void m_reset();
      m_hist.delete();
      for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b1);
      m_db = 1; m_run = 0; m_press = 0; m_spin = 0; m_brake = 0; m_period = FAST;
   endfunction

   initial m_reset();

   always @(posedge clk or negedge nrst) begin
      if (!nrst) m_reset();
      else begin
         m_ks = m_hist[SYNC-1];
         m_hit = m_spin && cyc == due;
         m_was_spin = m_spin;
         m_was_brake = m_brake;
         m_fire = 0;
         if (m_ks != m_db) begin
            m_run++;
            if (m_run == DEB) begin m_db = m_ks; m_run = 0; m_fire = !m_ks; end
         end else m_run = 0;
         if (!m_spin) begin
            if (m_press) begin m_spin = 1; m_period = FAST; due = cyc + FAST; end
         end else if (m_hit) begin
            if (!m_brake) due = cyc + m_period;
            else if (m_period + INC <= SLOW) begin m_period += INC; due = cyc + m_period; end
            else begin m_spin = 0; m_brake = 0; end
         end
         if (m_press && m_was_spin && !m_was_brake) m_brake = 1;
         m_press = m_fire;
         m_hist.push_front(key_n);
         void'(m_hist.pop_back());
         cyc++;
      end
   end

   always @(negedge clk) begin
      ncyc++;
      if (step === 1'b1) stimes.push_back(ncyc);
      chk("model step", step, (m_spin && cyc == due));
      chk("model spinning", spinning, m_spin);
      chk("model braking", braking, m_brake);
      chk("model period", period, m_period);
   end

   task automatic go(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   function automatic logic cond(input int sel);
      return sel == 0 ? step : sel == 1 ? braking : !spinning;
   endfunction

   task automatic wait_for(input string name, input int sel, input int maxc);
      int n = 0;
      while (!cond(sel) && n < maxc) begin go(1); n++; end
      chk({name, " wait"}, cond(sel), 1);
   endtask

   initial begin
      int pre, rise, n;
      go(2);
      chk("reset step", step, 0);
      chk("reset spinning", spinning, 0);
      chk("reset period", period, FAST);
      nrst = 1;
      go(50);
      chk("idle steps", stimes.size(), 0);
      chk("idle spinning", spinning, 0);
      chk("idle period", period, 4);
      for (int i = 0; i < 3; i++) begin key_n = 0; go(2); key_n = 1; go(2); end
      go(10);
      chk("glitch spinning", spinning, 0);
      chk("glitch steps", stimes.size(), 0);
      key_n = 0; go(6);
      chk("press latency pre", spinning, 0);
      go(1);
      chk("press spinning", spinning, 1);
      go(3);
      chk("first step", step, 1);
      key_n = 1; go(4);
      chk("second step", step, 1);
      go(20);
      chk("release spinning", spinning, 1);
      chk("release braking", braking, 0);
      chk("spin gap", stimes[stimes.size()-1] - stimes[stimes.size()-2], 4);
      key_n = 0; go(7);
      chk("brake rise", braking, 1);
      rise = ncyc;
      go(3); key_n = 1;
      pre = 0;
      foreach (stimes[i]) if (stimes[i] < rise) pre = i;
      wait_for("halt", 2, 100);
      n = stimes.size() - 1 - pre;
      chk("brake step count", n, 5);
      if (n == 5)
         for (int k = 1; k <= 5; k++) chk("brake gap", stimes[pre+k] - stimes[pre+k-1], 2 + 2 * k);
      chk("halt period", period, 12);
      chk("halt braking", braking, 0);
      n = stimes.size();
      go(30);
      chk("halt no steps", stimes.size(), n);
      key_n = 0; go(10); key_n = 1; go(10);
      wait_for("spin step", 0, 10);
      go(2); key_n = 0; go(6);
      chk("coincide step", step, 1);
      chk("coincide pre braking", braking, 0);
      go(1);
      chk("coincide braking", braking, 1);
      chk("coincide period", period, 4);
      go(3);
      chk("coincide next step", step, 1);
      chk("coincide next period", period, 4);
      key_n = 1; go(1);
      chk("coincide period grow", period, 6);
      wait_for("halt2", 2, 100);
      go(10);
      key_n = 0; go(10); key_n = 1; go(10);
      key_n = 0; go(10); key_n = 1;
      wait_for("braking", 1, 20);
      wait_for("brake step a", 0, 20);
      go(1);
      wait_for("brake step b", 0, 20);
      #1 nrst = 0;
      #1;
      chk("async step", step, 0);
      chk("async spinning", spinning, 0);
      chk("async braking", braking, 0);
      chk("async period", period, 4);
      go(3); nrst = 1;
      n = stimes.size();
      go(5);
      chk("post reset steps", stimes.size(), n);
      key_n = 0; go(7);
      chk("restart spinning", spinning, 1);
      go(3);
      chk("restart step", step, 1);
      go(4);
      chk("restart interval", step, 1);
      key_n = 1; go(20);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
